// File: rtl/mm2s_drain.sv
// mm2s_drain: drains N1 banked result memories onto an AXI-Stream master.
//
// All banks are read at a common address. Read data returns RD_LAT cycles
// after rd_en and lands in a word FIFO. A serialiser slices each N1-element
// word into N1/PACK beats, first element in the low bits of tdata.
// Reads are issued only while (in-flight + FIFO occupancy) < FIFO_DEPTH,
// so returning data always has room and backpressure never drops words.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle pulse, accepted only in IDLE
//   n_words                bank addresses to drain
//   row_elems, tlast_mode  TLAST per row (mode 1) or on the final beat only
//   busy, done             transfer in progress / one-cycle completion pulse
//   rd_en, rd_addr         bank read strobe and address
//   rd_data                bank b at [b*D_W +: D_W], valid RD_LAT after rd_en
//   m_axis_*               AXI-Stream master
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing reads until n_words have been issued
// FLUSH  | all reads issued; waiting for the final beat handshake
// DONE   | done pulse for one cycle
module mm2s_drain #(
    parameter int D_W          = 32,
    parameter int N1           = 4,
    parameter int PACK         = 1,
    parameter int ADDR_W       = 12,
    parameter int RD_LAT       = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int MATRIXSIZE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] n_words,
    input  logic [MATRIXSIZE_W-1:0] row_elems,
    input  logic                    tlast_mode,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [N1*D_W-1:0]       rd_data,
    output logic [PACK*D_W-1:0]     m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int BPW    = N1 / PACK;
    localparam int CW     = MATRIXSIZE_W + $clog2(N1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CNTW   = PW + 1;
    localparam int BW     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WW     = N1 * D_W;
    localparam int BEAT_W = PACK * D_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [MATRIXSIZE_W-1:0] n_words_q, n_words_d;
    logic [MATRIXSIZE_W-1:0] row_elems_q, row_elems_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           tot_beats_q, tot_beats_d;
    logic [CW-1:0]           iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]           ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]           row_cnt_q, row_cnt_d;
    logic [RD_LAT-1:0]       cap_v_q, cap_v_d;
    logic [CNTW-1:0]         inflight_q, inflight_d;
    logic [CNTW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    tvalid_q, tvalid_d;
    logic [BEAT_W-1:0]       tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    final_q, final_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [WW-1:0]           fifo_mem_q [FIFO_DEPTH];

    logic            rd_en_c, cap_valid, hs, pop, load_ok, src_ok, off, row_hit;
    logic [CNTW:0]   credit_used;
    logic [PW-1:0]   head_ptr;
    logic [WW-1:0]   src_word;
    logic [BW-1:0]   nxt_beat;

    always_comb begin
        state_d     = state_q;
        n_words_d   = n_words_q;
        row_elems_d = row_elems_q;
        mode_d      = mode_q;
        tot_beats_d = tot_beats_q;
        iss_cnt_d   = iss_cnt_q;
        ld_cnt_d    = ld_cnt_q;
        row_cnt_d   = row_cnt_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        final_d     = final_q;
        beat_d      = beat_q;
        src_ok      = 1'b0;
        src_word    = '0;
        nxt_beat    = '0;
        off         = 1'b0;
        head_ptr    = rd_ptr_q;
        row_hit     = 1'b0;

        credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
        rd_en_c     = (state_q == S_RUN) && (iss_cnt_q < CW'(n_words_q))
                      && (credit_used < (CNTW+1)'(FIFO_DEPTH));
        cap_valid   = cap_v_q[RD_LAT-1];
        cap_v_d[0]  = rd_en_c;
        for (int i = 1; i < RD_LAT; i++) cap_v_d[i] = cap_v_q[i-1];

        hs      = tvalid_q && m_axis_tready;
        pop     = hs && (beat_q == BW'(BPW - 1));
        load_ok = !tvalid_q || m_axis_tready;

        inflight_d = inflight_q + CNTW'(rd_en_c) - CNTW'(cap_valid);
        fifo_cnt_d = fifo_cnt_q + CNTW'(cap_valid) - CNTW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(cap_valid);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        iss_cnt_d  = iss_cnt_q + CW'(rd_en_c);

        // Next beat comes from the head word, or from the word behind it when
        // the head is being popped; an empty slot is bypassed from rd_data
        // so the first beat is not delayed by the FIFO write.
        if (load_ok) begin
            if (tvalid_q && !pop) begin
                src_ok   = 1'b1;
                src_word = fifo_mem_q[rd_ptr_q];
                nxt_beat = beat_q + BW'(1);
            end else begin
                off      = tvalid_q;
                head_ptr = rd_ptr_q + PW'(off);
                if (fifo_cnt_q > CNTW'(off)) begin
                    src_ok   = 1'b1;
                    src_word = fifo_mem_q[head_ptr];
                end else if ((fifo_cnt_q == CNTW'(off)) && cap_valid) begin
                    src_ok   = 1'b1;
                    src_word = rd_data;
                end
            end
            tvalid_d = src_ok;
            if (src_ok) begin
                beat_d    = nxt_beat;
                tdata_d   = src_word[int'(nxt_beat) * BEAT_W +: BEAT_W];
                final_d   = (ld_cnt_q == tot_beats_q - CW'(1));
                row_hit   = mode_q && (row_cnt_q + CW'(PACK) == CW'(row_elems_q));
                tlast_d   = final_d || row_hit;
                row_cnt_d = row_hit ? '0 : row_cnt_q + CW'(PACK);
                ld_cnt_d  = ld_cnt_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_words_d   = n_words;
                    row_elems_d = row_elems;
                    mode_d      = tlast_mode;
                    tot_beats_d = CW'(n_words) * CW'(BPW);
                    iss_cnt_d   = '0;
                    ld_cnt_d    = '0;
                    row_cnt_d   = '0;
                    state_d     = (n_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (iss_cnt_d == CW'(n_words_q)) state_d = S_FLUSH;
            S_FLUSH: if (hs && final_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_words_q   <= '0;
            row_elems_q <= '0;
            mode_q      <= 1'b0;
            tot_beats_q <= '0;
            iss_cnt_q   <= '0;
            ld_cnt_q    <= '0;
            row_cnt_q   <= '0;
            cap_v_q     <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            final_q     <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_words_q   <= n_words_d;
            row_elems_q <= row_elems_d;
            mode_q      <= mode_d;
            tot_beats_q <= tot_beats_d;
            iss_cnt_q   <= iss_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            row_cnt_q   <= row_cnt_d;
            cap_v_q     <= cap_v_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            final_q     <= final_d;
            beat_q      <= beat_d;
        end
    end

    // Storage only; validity is tracked by the pointers and count above.
    always_ff @(posedge clk) begin
        if (cap_valid) fifo_mem_q[wr_ptr_q] <= rd_data;
    end

    assign busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done          = (state_q == S_DONE);
    assign rd_en         = rd_en_c;
    assign rd_addr       = ADDR_W'(iss_cnt_q);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_mm2s_drain.sv
// Bench for mm2s_drain: two instances (PACK=1 and PACK=2) run side by side
// on the same stimulus, each with its own bank model and scoreboard queue.
module tb_mm2s_drain;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tready = 1'b1;
    logic        tlast_mode = 1'b0;
    logic [15:0] n_words = '0;
    logic [15:0] row_elems = '0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    beat_t       exp_q [2][$];
    logic [1:0]  rd_en_a, busy_a, done_a, tvalid_a, tlast_a;
    logic [63:0] tdata_a [2];
    logic [11:0] rd_addr_a [2];
    int first_rd[2], first_v[2], last_hs[2], hs_cnt[2];
    int done_cnt[2], done_cyc[2], any_v[2], any_rd[2];
    int start_cyc;

    function automatic logic [127:0] bank_word(input logic [11:0] a);
        logic [127:0] w;
        for (int b = 0; b < 4; b++) w[b*32 +: 32] = 32'(a) * 32'd16 + 32'(b);
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int P = g + 1;
        logic          rd_en, busy, done, tvalid, tlast;
        logic [11:0]   rd_addr;
        logic [P*32-1:0] tdata;
        logic [127:0]  st1, st2;

        mm2s_drain #(
            .D_W(32), .N1(4), .PACK(P), .ADDR_W(12), .RD_LAT(2),
            .FIFO_DEPTH(8), .MATRIXSIZE_W(16)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words),
            .row_elems(row_elems), .tlast_mode(tlast_mode),
            .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
            .rd_data(st2), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
            .m_axis_tready(tready), .m_axis_tlast(tlast)
        );

        // Bank model with two-cycle read latency; garbage when not read.
        always @(posedge clk) begin
            st1 <= rd_en ? bank_word(rd_addr) : {4{32'hdeadbeef}};
            st2 <= st1;
        end

        assign rd_en_a[g]   = rd_en;
        assign busy_a[g]    = busy;
        assign done_a[g]    = done;
        assign tvalid_a[g]  = tvalid;
        assign tlast_a[g]   = tlast;
        assign tdata_a[g]   = 64'(tdata);
        assign rd_addr_a[g] = rd_addr;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int n, input int row, input bit mode);
        for (int g = 0; g < 2; g++) begin
            int p  = g + 1;
            int nb = n * 4 / p;
            for (int k = 0; k < nb; k++) begin
                beat_t b;
                b.data = '0;
                for (int j = 0; j < p; j++) begin
                    int e = k * p + j;
                    b.data[j*32 +: 32] = 32'((e / 4) * 16 + e % 4);
                end
                b.last = (k == nb - 1) || (mode && (((k + 1) * p) % row == 0));
                exp_q[g].push_back(b);
            end
        end
    endtask

    task automatic mon(input int g);
        int   issued = 0, words = 0, bw = 0, exp_addr = 0;
        int   bpw = 4 / (g + 1);
        bit   stall = 0;
        logic [63:0] pd = '0;
        logic pl = 1'b0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                issued = 0; words = 0; bw = 0; exp_addr = 0; stall = 0;
                continue;
            end
            if (start) begin
                issued = 0; words = 0; bw = 0; exp_addr = 0;
            end
            if (rd_en_a[g]) begin
                any_rd[g]++;
                if (first_rd[g] < 0) first_rd[g] = cyc;
                chk($sformatf("rd_addr%0d", g), 64'(rd_addr_a[g]), 64'(exp_addr));
                exp_addr++;
                issued++;
                chk($sformatf("credit%0d", g), 64'(issued - words <= 8), 64'(1));
            end
            if (stall) begin
                chk($sformatf("hold_valid%0d", g), 64'(tvalid_a[g]), 64'(1));
                chk($sformatf("hold_data%0d", g), tdata_a[g], pd);
                chk($sformatf("hold_last%0d", g), 64'(tlast_a[g]), 64'(pl));
            end
            if (tvalid_a[g]) begin
                any_v[g]++;
                if (first_v[g] < 0) first_v[g] = cyc;
                if (tready) begin
                    chk($sformatf("beat_expected%0d", g), 64'(exp_q[g].size() != 0), 64'(1));
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("tdata%0d", g), tdata_a[g], e.data);
                        chk($sformatf("tlast%0d", g), 64'(tlast_a[g]), 64'(e.last));
                    end
                    hs_cnt[g]++;
                    last_hs[g] = cyc;
                    bw++;
                    if (bw == bpw) begin bw = 0; words++; end
                    stall = 0;
                end else begin
                    stall = 1; pd = tdata_a[g]; pl = tlast_a[g];
                end
            end else begin
                stall = 0;
            end
            if (done_a[g]) begin
                done_cnt[g]++;
                if (done_cyc[g] < 0) done_cyc[g] = cyc;
                chk($sformatf("busy_at_done%0d", g), 64'(busy_a[g]), 64'(0));
            end
        end
    endtask

    task automatic reset_chk(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_busy%0d", tag, g), 64'(busy_a[g]), 64'(0));
            chk($sformatf("%s_done%0d", tag, g), 64'(done_a[g]), 64'(0));
            chk($sformatf("%s_rd_en%0d", tag, g), 64'(rd_en_a[g]), 64'(0));
            chk($sformatf("%s_tvalid%0d", tag, g), 64'(tvalid_a[g]), 64'(0));
            chk($sformatf("%s_tlast%0d", tag, g), 64'(tlast_a[g]), 64'(0));
            chk($sformatf("%s_rd_addr%0d", tag, g), 64'(rd_addr_a[g]), 64'(0));
        end
    endtask

    task automatic launch(input int n, input int row, input bit mode);
        push_exp(n, row, mode);
        for (int g = 0; g < 2; g++) begin
            first_rd[g] = -1; first_v[g] = -1; last_hs[g] = -1; hs_cnt[g] = 0;
            done_cnt[g] = 0; done_cyc[g] = -1; any_v[g] = 0; any_rd[g] = 0;
        end
        @(posedge clk); #1;
        n_words = 16'(n); row_elems = 16'(row); tlast_mode = mode;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (n > 0) chk("busy_rise", 64'(busy_a), 64'(2'b11));
        else       chk("busy_zero", 64'(busy_a), 64'(2'b00));
    endtask

    task automatic wait_done(input int pct);
        int t = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && t < 4000) begin
            @(posedge clk); #1;
            tready = ($urandom_range(0, 99) >= pct);
            t++;
        end
        chk("done_timeout", 64'(done_cnt[0] == 0 || done_cnt[1] == 0), 64'(0));
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("done_pulses%0d", g), 64'(done_cnt[g]), 64'(1));
            chk($sformatf("beats_left%0d", g), 64'(exp_q[g].size()), 64'(0));
        end
    endtask

    task automatic thru_chk(input int n);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("first_latency%0d", g), 64'(first_v[g] - first_rd[g]), 64'(3));
            chk($sformatf("back_to_back%0d", g), 64'(last_hs[g] - first_v[g]), 64'(n * 4 / (g + 1) - 1));
        end
    endtask

    initial begin
        int t;
        fork
            mon(0);
            mon(1);
        join_none

        repeat (2) @(posedge clk);
        #1;
        reset_chk("reset");
        rst_n = 1'b1;

        // whole-matrix tlast, full throughput
        launch(3, 4, 1'b0);
        wait_done(0);
        thru_chk(3);

        // per-row tlast
        launch(3, 6, 1'b1);
        wait_done(0);
        thru_chk(3);

        // random backpressure
        launch(64, 4, 1'b0);
        wait_done(30);

        // empty transfer
        launch(0, 4, 1'b0);
        wait_done(0);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("zero_done_lat%0d", g),
                64'((done_cyc[g] - start_cyc >= 1) && (done_cyc[g] - start_cyc <= 2)), 64'(1));
            chk($sformatf("zero_tvalid%0d", g), 64'(any_v[g]), 64'(0));
            chk($sformatf("zero_rd_en%0d", g), 64'(any_rd[g]), 64'(0));
        end

        // reset mid-transfer, then a fresh transfer
        launch(10, 4, 1'b0);
        t = 0;
        while (hs_cnt[0] < 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("abort_reach", 64'(hs_cnt[0] >= 5), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        reset_chk("abort");
        for (int g = 0; g < 2; g++) exp_q[g].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        launch(5, 8, 1'b1);
        wait_done(20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
